// File: rtl/fft_frame_feeder.sv
// fft_frame_feeder: collects one N-sample complex frame from a valid/ready
// stream into a local buffer. When fft_64 reports ready, it issues a
// one-cycle start pulse and then plays the frame back-to-back, one sample
// per cycle.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   s_valid/s_ready      upstream handshake; s_real/s_imag carry the sample
//   fft_ready            ready indication from fft_64
//   fft_start            one-cycle start pulse to fft_64
//   fft_real/fft_imag    sample stream to fft_64, zero outside frame samples
//   busy                 high in any state other than fill
//   frames_sent          count of completed frames, wraps at 16 bits
//
// All outputs come straight from flops.
module fft_frame_feeder #(
  parameter int unsigned N  = 64,
  parameter int unsigned W  = 16,
  parameter int unsigned AW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [W-1:0]  s_real,
  input  logic [W-1:0]  s_imag,
  input  logic          fft_ready,
  output logic          fft_start,
  output logic [W-1:0]  fft_real,
  output logic [W-1:0]  fft_imag,
  output logic          busy,
  output logic [15:0]   frames_sent
);

  typedef enum logic [1:0] {
    StFill    = 2'd0,
    StWaitRdy = 2'd1,
    StStream  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  // One bit wider than the address so the slot after the last sample
  // (count == N) can be told apart from sample 0.
  logic [AW:0]     rd_cnt_q, rd_cnt_d;
  logic            s_ready_q, s_ready_d;
  logic            start_q, start_d;
  logic [W-1:0]    real_q, real_d;
  logic [W-1:0]    imag_q, imag_d;
  logic            busy_q, busy_d;
  logic [15:0]     frames_q, frames_d;
  logic            wr_en;
  logic [2*W-1:0]  rd_word;

  // Frame buffer, {real, imag} per entry. Contents need no reset.
  logic [2*W-1:0]  mem [N];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= {s_real, s_imag};
    end
  end

  assign rd_word = mem[rd_cnt_q[AW-1:0]];

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_cnt_d  = rd_cnt_q;
    s_ready_d = s_ready_q;
    frames_d  = frames_q;
    start_d   = 1'b0;
    real_d    = '0;
    imag_d    = '0;
    wr_en     = 1'b0;

    unique case (state_q)
      StFill: begin
        s_ready_d = 1'b1;
        if (s_valid && s_ready_q) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          // Last accept closes the frame; s_ready falls at this same edge.
          if (wr_ptr_q == AW'(N - 1)) begin
            state_d   = StWaitRdy;
            s_ready_d = 1'b0;
          end
        end
      end

      StWaitRdy: begin
        s_ready_d = 1'b0;
        if (fft_ready) begin
          start_d  = 1'b1;
          rd_cnt_d = '0;
          state_d  = StStream;
        end
      end

      StStream: begin
        s_ready_d = 1'b0;
        // fft_ready is deliberately ignored here: playback never pauses.
        if (rd_cnt_q == (AW + 1)'(N)) begin
          state_d   = StFill;
          wr_ptr_d  = '0;
          s_ready_d = 1'b1;
          frames_d  = frames_q + 16'd1;
        end else begin
          real_d   = rd_word[2*W-1:W];
          imag_d   = rd_word[W-1:0];
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d   = StFill;
        wr_ptr_d  = '0;
        s_ready_d = 1'b1;
      end
    endcase

    busy_d = (state_d != StFill);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFill;
      wr_ptr_q  <= '0;
      rd_cnt_q  <= '0;
      s_ready_q <= 1'b1;
      start_q   <= 1'b0;
      real_q    <= '0;
      imag_q    <= '0;
      busy_q    <= 1'b0;
      frames_q  <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_cnt_q  <= rd_cnt_d;
      s_ready_q <= s_ready_d;
      start_q   <= start_d;
      real_q    <= real_d;
      imag_q    <= imag_d;
      busy_q    <= busy_d;
      frames_q  <= frames_d;
    end
  end

  assign s_ready     = s_ready_q;
  assign fft_start   = start_q;
  assign fft_real    = real_q;
  assign fft_imag    = imag_q;
  assign busy        = busy_q;
  assign frames_sent = frames_q;

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Directed bench for fft_frame_feeder. Samples pushed into a scoreboard
// queue as they are accepted upstream are popped and compared as the
// frame streams out towards fft_64.
module tb_fft_frame_feeder;

  localparam int unsigned N  = 64;
  localparam int unsigned W  = 16;
  localparam int unsigned AW = 6;

  logic          clk;
  logic          rst_n;
  logic          s_valid;
  logic          s_ready;
  logic [W-1:0]  s_real;
  logic [W-1:0]  s_imag;
  logic          fft_ready;
  logic          fft_start;
  logic [W-1:0]  fft_real;
  logic [W-1:0]  fft_imag;
  logic          busy;
  logic [15:0]   frames_sent;

  int            n_vec;
  int            n_err;
  logic [15:0]   fs_exp;
  logic [31:0]   sb[$];

  fft_frame_feeder #(
    .N  (N),
    .W  (W),
    .AW (AW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_real      (s_real),
    .s_imag      (s_imag),
    .fft_ready   (fft_ready),
    .fft_start   (fft_start),
    .fft_real    (fft_real),
    .fft_imag    (fft_imag),
    .busy        (busy),
    .frames_sent (frames_sent)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_start"}, 32'(fft_start), 32'd0);
    chk({tag, "_real"}, 32'(fft_real), 32'd0);
    chk({tag, "_imag"}, 32'(fft_imag), 32'd0);
  endtask

  // kind 0: impulse, 1: ramp (re=k, im=-k), 2: random.
  task automatic send_frame(input int kind, input bit stall, input bit hold_valid);
    logic [W-1:0] re;
    logic [W-1:0] im;
    for (int k = 0; k < int'(N); k++) begin
      if (stall) begin
        s_valid = 1'b0;
        tick();
        chk("fill_idle_rdy", 32'(s_ready), 32'd1);
      end
      case (kind)
        0:       begin re = (k == 0) ? 16'h0100 : 16'h0000; im = 16'h0000; end
        1:       begin re = W'(k); im = W'(-k); end
        default: begin re = W'($urandom); im = W'($urandom); end
      endcase
      s_valid = 1'b1;
      s_real  = re;
      s_imag  = im;
      chk("fill_rdy", 32'(s_ready), 32'd1);
      chk("fill_busy", 32'(busy), 32'd0);
      tick();
      sb.push_back({re, im});
    end
    // Edge after the last accept: s_ready must already be low.
    chk("rdy_drop", 32'(s_ready), 32'd0);
    chk("busy_rise", 32'(busy), 32'd1);
    if (hold_valid) begin
      // Junk held on the bus; a stray write would corrupt buf[0].
      s_valid = 1'b1;
      s_real  = 16'h7777;
      s_imag  = 16'h7777;
    end else begin
      s_valid = 1'b0;
    end
  endtask

  // Returns 1 when reset was applied mid-stream at sample reset_at.
  task automatic stream_frame(input int wait_cycles, input int drop_at, input int reset_at,
                              output bit aborted);
    logic [31:0] exp;
    aborted = 1'b0;
    fft_ready = (wait_cycles == 0);
    for (int i = 0; i < wait_cycles; i++) begin
      tick();
      chk_idle_outputs("wait");
      chk("wait_rdy", 32'(s_ready), 32'd0);
      chk("wait_busy", 32'(busy), 32'd1);
    end
    fft_ready = 1'b1;
    tick();
    chk("start_hi", 32'(fft_start), 32'd1);
    chk("start_real", 32'(fft_real), 32'd0);
    chk("start_imag", 32'(fft_imag), 32'd0);
    chk("start_rdy", 32'(s_ready), 32'd0);
    s_valid = 1'b0;
    for (int k = 0; k < int'(N); k++) begin
      tick();
      if (k == reset_at) begin
        #3;
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("arst");
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_rdy", 32'(s_ready), 32'd1);
        chk("arst_frames", 32'(frames_sent), 32'd0);
        sb.delete();
        aborted = 1'b1;
        return;
      end
      if (sb.size() == 0) begin
        chk("sb_empty", 32'(sb.size()), 32'd1);
        exp = '0;
      end else begin
        exp = sb.pop_front();
      end
      chk("smp_real", 32'(fft_real), 32'(exp[31:16]));
      chk("smp_imag", 32'(fft_imag), 32'(exp[15:0]));
      chk("smp_start", 32'(fft_start), 32'd0);
      chk("smp_rdy", 32'(s_ready), 32'd0);
      chk("smp_busy", 32'(busy), 32'd1);
      if (k == drop_at) fft_ready = 1'b0;
    end
    tick();
    fs_exp = fs_exp + 16'd1;
    chk_idle_outputs("end");
    chk("end_rdy", 32'(s_ready), 32'd1);
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_frames", 32'(frames_sent), 32'(fs_exp));
    fft_ready = 1'b1;
  endtask

  initial begin
    bit ab;
    n_vec     = 0;
    n_err     = 0;
    fs_exp    = '0;
    rst_n     = 1'b0;
    s_valid   = 1'b0;
    s_real    = '0;
    s_imag    = '0;
    fft_ready = 1'b0;

    repeat (2) tick();
    chk_idle_outputs("rst");
    chk("rst_rdy", 32'(s_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frames", 32'(frames_sent), 32'd0);
    #2 rst_n = 1'b1;
    tick();

    // Impulse, valid held high throughout, fft_ready already high.
    fft_ready = 1'b1;
    send_frame(0, 1'b0, 1'b1);
    stream_frame(0, -1, -1, ab);

    // Ramp with upstream stalls every other cycle.
    send_frame(1, 1'b1, 1'b0);
    stream_frame(0, -1, -1, ab);

    // Late ready: 20 cycles of waiting.
    fft_ready = 1'b0;
    send_frame(2, 1'b0, 1'b0);
    stream_frame(20, -1, -1, ab);

    // fft_ready drops at stream sample 10.
    send_frame(2, 1'b0, 1'b0);
    stream_frame(0, 10, -1, ab);

    // Asynchronous reset at stream sample 30.
    send_frame(1, 1'b0, 1'b0);
    stream_frame(0, -1, 30, ab);
    chk("arst_taken", 32'(ab), 32'd1);
    #2 rst_n = 1'b1;
    fs_exp = '0;
    tick();
    chk("post_rst_rdy", 32'(s_ready), 32'd1);
    chk("post_rst_frames", 32'(frames_sent), 32'd0);
    send_frame(2, 1'b0, 1'b0);
    stream_frame(0, -1, -1, ab);

    // Counter wrap: park the counter at 0xFFFF while filling is idle.
    force dut.frames_q = 16'hFFFF;
    tick();
    release dut.frames_q;
    tick();
    fs_exp = 16'hFFFF;
    chk("wrap_pre", 32'(frames_sent), 32'(fs_exp));
    send_frame(2, 1'b0, 1'b0);
    stream_frame(0, -1, -1, ab);
    chk("wrap_zero", 32'(frames_sent), 32'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
